svm_window_scheduler: RTL and testbench

- Sequences the SVM coefficient ROM for one classification window of NUM_COEF HOG features.
- Accepts a feature stream and issues the matching ROM address for each accepted feature.
- Aligns each feature with the ROM's 1-cycle registered data, multiply-accumulates, adds a bias and presents a signed score plus detect flag on a valid/ready output.
- Sits between the HOG normaliser and the detection-window bookkeeping logic.

---
 rtl/svm_window_scheduler.sv | 137 +++++++++++++
 tb/tb_svm_window_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/svm_window_scheduler.sv
// SVM window scheduler: walks the coefficient ROM in step with an incoming
// HOG feature stream, multiply-accumulates one window of NUM_COEF features,
// adds the bias and hands out a signed score plus detect flag on valid/ready.
module svm_window_scheduler #(
   parameter int     NUM_COEF   = 36,
   parameter int     FEAT_WIDTH = 16,
   parameter int     COEF_WIDTH = 20,
   parameter longint BIAS       = 0,
   localparam int    ACC_WIDTH  = FEAT_WIDTH + COEF_WIDTH + $clog2(NUM_COEF),
   localparam int    ADDR_WIDTH = $clog2(NUM_COEF)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear_i,
   input  logic                         feature_valid_i,
   output logic                         feature_ready_o,
   input  logic signed [FEAT_WIDTH-1:0] feature_data_i,
   output logic        [ADDR_WIDTH-1:0] coef_addr_o,
   input  logic signed [COEF_WIDTH-1:0] coef_data_i,
   output logic                         score_valid_o,
   input  logic                         score_ready_i,
   output logic signed [ACC_WIDTH-1:0]  score_o,
   output logic                         detect_o,
   output logic                         busy_o
);

   localparam int PROD_WIDTH = FEAT_WIDTH + COEF_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_COEF - 1);
   localparam logic signed [ACC_WIDTH-1:0] BIAS_EXT = ACC_WIDTH'(BIAS);

   typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_RESULT} state_t;

   state_t                        state_q, state_d;
   logic [ADDR_WIDTH-1:0]         idx_q;
   logic signed [FEAT_WIDTH-1:0]  feature_d_q;
   logic                          mul_v_q;
   logic signed [ACC_WIDTH-1:0]   acc_q;
   logic signed [ACC_WIDTH-1:0]   score_q;
   logic                          detect_q;
   logic                          score_valid_q;
   logic                          busy_q;

   logic                          accept;
   logic                          last_accept;
   logic                          handshake;
   logic signed [PROD_WIDTH-1:0]  prod_full;
   logic signed [ACC_WIDTH-1:0]   prod_term;
   logic signed [ACC_WIDTH-1:0]   acc_sum;
   logic signed [ACC_WIDTH-1:0]   score_sum;

   assign accept      = feature_valid_i && feature_ready_o;
   assign last_accept = accept && (idx_q == LAST_IDX);
   assign handshake   = score_valid_q && score_ready_i;

   // Feature register lines up with the ROM's registered output one cycle later.
   assign prod_full = feature_d_q * coef_data_i;
   assign prod_term = mul_v_q ? {{(ACC_WIDTH - PROD_WIDTH){prod_full[PROD_WIDTH-1]}}, prod_full}
                              : '0;
   assign acc_sum   = acc_q + prod_term;
   assign score_sum = acc_sum + BIAS_EXT;

   // Address comes straight from the registered index so the ROM samples it
   // on the same edge that accepts the feature.
   assign coef_addr_o   = idx_q;
   assign score_valid_o = score_valid_q;
   assign score_o       = score_q;
   assign detect_o      = detect_q;
   assign busy_o        = busy_q;

   // State register; clear aborts back to ACCUM just like reset.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         state_q <= ST_ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accumulate a full window, one drain cycle, then hold the result.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ACCUM:  if (last_accept) state_d = ST_DRAIN;
         ST_DRAIN:  state_d = ST_RESULT;
         ST_RESULT: if (handshake) state_d = ST_ACCUM;
         default:   state_d = ST_ACCUM;
      endcase
   end

   // Outputs: features only flow in ACCUM and never during reset or clear.
   always_comb begin
      feature_ready_o = (state_q == ST_ACCUM) && !reset && !clear_i;
   end

   // Datapath: index, feature alignment, accumulator and held result.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q         <= '0;
         feature_d_q   <= '0;
         mul_v_q       <= 1'b0;
         acc_q         <= '0;
         score_q       <= '0;
         detect_q      <= 1'b0;
         score_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else if (clear_i) begin
         idx_q         <= '0;
         mul_v_q       <= 1'b0;
         acc_q         <= '0;
         score_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         mul_v_q <= accept;
         if (accept) begin
            feature_d_q <= feature_data_i;
            idx_q       <= last_accept ? '0 : idx_q + ADDR_WIDTH'(1);
            if (idx_q == '0) begin
               busy_q <= 1'b1;
            end
         end
         if (state_q == ST_DRAIN) begin
            // Final product folds in here together with the bias.
            score_q       <= score_sum;
            detect_q      <= !score_sum[ACC_WIDTH-1] && (score_sum != '0);
            acc_q         <= '0;
            score_valid_q <= 1'b1;
         end else begin
            acc_q <= acc_sum;
         end
         if (handshake) begin
            score_valid_q <= 1'b0;
            busy_q        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_svm_window_scheduler.sv
// Directed bench for svm_window_scheduler: four instances share one stimulus
// stream and differ only in BIAS so every bias boundary is seen per window.
module tb_svm_window_scheduler;

   localparam int NI = 4;
   localparam int N  = 36;

   logic clk = 1'b0;
   logic reset;
   logic clear_i;
   logic feature_valid_i;
   logic signed [15:0] feature_data_i;
   logic score_ready_i;

   logic               ready_w  [NI];
   logic [5:0]         addr_w   [NI];
   logic signed [19:0] coef_q   [NI];
   logic               sv_w     [NI];
   logic signed [41:0] score_w  [NI];
   logic               detect_w [NI];
   logic               busy_w   [NI];

   logic signed [19:0] coef_mem [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic longint bias_of(int k);
      return (k == 0) ? -600 : (k == 1) ? -630 : (k == 2) ? -631 : 0;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      svm_window_scheduler #(
         .NUM_COEF(36), .FEAT_WIDTH(16), .COEF_WIDTH(20),
         .BIAS((gi == 0) ? -64'sd600 : (gi == 1) ? -64'sd630 : (gi == 2) ? -64'sd631 : 64'sd0)
      ) u_dut (
         .clk(clk),
         .reset(reset),
         .clear_i(clear_i),
         .feature_valid_i(feature_valid_i),
         .feature_ready_o(ready_w[gi]),
         .feature_data_i(feature_data_i),
         .coef_addr_o(addr_w[gi]),
         .coef_data_i(coef_q[gi]),
         .score_valid_o(sv_w[gi]),
         .score_ready_i(score_ready_i),
         .score_o(score_w[gi]),
         .detect_o(detect_w[gi]),
         .busy_o(busy_w[gi])
      );
      always @(posedge clk) coef_q[gi] <= coef_mem[addr_w[gi]];
   end

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rom_ramp();
      for (int i = 0; i < N; i++) coef_mem[i] = 20'(i);
   endtask

   task automatic rom_min();
      for (int i = 0; i < N; i++) coef_mem[i] = -20'sd524288;
   endtask

   // Feed n features; optional random idle gaps before each accept.
   task automatic feed(input logic signed [15:0] f, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
               feature_valid_i = 1'b0;
               chk("gap_addr_hold", addr_w[3], i);
               step();
            end
         end
         feature_valid_i = 1'b1;
         feature_data_i  = f;
         chk("accept_ready", ready_w[3], 1);
         chk("accept_addr", addr_w[3], i);
         chk("no_early_result", sv_w[3], 0);
         step();
         if (i == 0) chk("busy_after_first", busy_w[3], 1);
      end
      feature_valid_i = 1'b0;
   endtask

   // Full window followed by the two-cycle latency check.
   task automatic window(input logic signed [15:0] f, input bit gaps);
      chk("busy_idle", busy_w[3], 0);
      feed(f, N, gaps);
      chk("drain_not_valid", sv_w[3], 0);
      chk("drain_not_ready", ready_w[3], 0);
      step();
      chk("latency_valid", sv_w[3], 1);
      chk("busy_in_result", busy_w[3], 1);
   endtask

   task automatic check_scores(input string tag, input longint base);
      for (int k = 0; k < NI; k++) begin
         longint e;
         e = base + bias_of(k);
         chk({tag, "_score"}, score_w[k], e);
         chk({tag, "_detect"}, detect_w[k], (e > 0) ? 1 : 0);
      end
   endtask

   task automatic take_result();
      score_ready_i = 1'b1;
      step();
      score_ready_i = 1'b0;
      chk("hs_valid_low", sv_w[3], 0);
      chk("hs_busy_low", busy_w[3], 0);
      chk("hs_ready_back", ready_w[3], 1);
   endtask

   initial begin
      reset = 1'b1; clear_i = 1'b0; feature_valid_i = 1'b0;
      feature_data_i = '0; score_ready_i = 1'b0;
      rom_ramp();
      step(); step();
      chk("rst_ready", ready_w[3], 0);
      chk("rst_valid", sv_w[3], 0);
      chk("rst_busy", busy_w[3], 0);
      chk("rst_score", score_w[3], 0);
      chk("rst_detect", detect_w[3], 0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", ready_w[3], 1);
      chk("post_rst_addr", addr_w[3], 0);

      // Window A: ramp ROM, +1 features; biases -600/-630/-631/0.
      window(16'sd1, 1'b0);
      check_scores("ramp", 630);
      // Consumer stalls for 5 cycles: result must hold, no features accepted.
      for (int c = 0; c < 5; c++) begin
         step();
         chk("stall_valid", sv_w[3], 1);
         chk("stall_score", score_w[0], 30);
         chk("stall_detect", detect_w[0], 1);
         chk("stall_ready", ready_w[3], 0);
      end
      take_result();

      // Window B starts right after the handshake, with random gaps.
      window(16'sd2, 1'b1);
      check_scores("gaps", 1260);
      take_result();

      // Window C: extreme negative operands, sum must stay positive.
      rom_min();
      window(-16'sd32768, 1'b0);
      check_scores("extreme", 64'sd618475290624);
      take_result();
      rom_ramp();

      // Clear after 20 accepts, then a clean window.
      feed(16'sd1, 20, 1'b0);
      feature_valid_i = 1'b1;
      clear_i = 1'b1;
      #1;
      chk("clear_ready_low", ready_w[3], 0);
      step();
      clear_i = 1'b0;
      feature_valid_i = 1'b0;
      #1;
      chk("clear_busy", busy_w[3], 0);
      chk("clear_valid", sv_w[3], 0);
      chk("clear_addr", addr_w[3], 0);
      window(16'sd1, 1'b0);
      check_scores("after_clear", 630);
      take_result();

      // Reset after 20 accepts, then a clean window.
      feed(16'sd1, 20, 1'b0);
      feature_valid_i = 1'b1;
      reset = 1'b1;
      #1;
      chk("rst_mid_ready", ready_w[3], 0);
      step();
      reset = 1'b0;
      feature_valid_i = 1'b0;
      #1;
      chk("rst_mid_busy", busy_w[3], 0);
      chk("rst_mid_valid", sv_w[3], 0);
      chk("rst_mid_addr", addr_w[3], 0);
      window(16'sd1, 1'b0);
      check_scores("after_reset", 630);

      // A pending result is discarded by clear.
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      chk("discard_valid", sv_w[3], 0);
      chk("discard_busy", busy_w[3], 0);
      step();
      chk("discard_stays_low", sv_w[3], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
